cpu_trace_monitor: RTL and testbench
====================================

Name: cpu_trace_monitor

Overview:
- Synthesizable, parametrised run monitor that sits beside the CPU core. It taps the register-file write port and the halt line.
- Produces a cycle-stamped trace of architectural register writes, buffered in a FIFO and drained over a valid/ready stream.
- Counts run cycles and dropped records, and signals completion once the CPU halts and the trace has drained.
- Replaces per-cycle full-register dumps with write-only change records usable in simulation and on hardware.

Parameters:
XLEN, 32, register data width
NUM_REGS, 32, architectural register count; AW = clog2(NUM_REGS)
CYC_W, 32, cycle counter width
DEPTH, 16, trace FIFO entries (power of two, >= 2)
DROP_W, 16, dropped-record counter width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin monitoring (sampled in IDLE)
halt  in  1  CPU halt indication (level)
rf_we  in  1  register-file write enable
rf_waddr  in  AW  register-file write address
rf_wdata  in  XLEN  register-file write data
out_valid  out  1  trace record available
out_ready  in  1  consumer accepts record
out_data  out  CYC_W+AW+XLEN  {cycle, addr, data}, cycle in MSBs
cycle_count  out  CYC_W  RUN cycles elapsed
drop_count  out  DROP_W  records lost to FIFO full
busy  out  1  state is RUN or DRAIN
done  out  1  sticky: halted and trace fully drained

Behaviour:
- Reset: one clock, synchronous, active-high. State = IDLE; FIFO empty; out_valid=0; cycle_count=0; drop_count=0; busy=0; done=0. Reset mid-run discards all buffered records.
- FSM:
  - IDLE -> RUN when start=1. start is ignored in all other states.
  - RUN -> DRAIN on the first clock with halt=1.
  - DRAIN -> DONE on a clock where the FIFO is empty. If the last record pops in a cycle, DONE is entered on the following edge.
  - DONE holds until reset.
- Cycle counter: increments by 1 on every RUN clock edge, saturating at all-ones. It is frozen in IDLE, DRAIN and DONE.
- Capture: in RUN, a clock with rf_we=1 and rf_waddr!=0 pushes {cycle_count, rf_waddr, rf_wdata}. The stamp is the pre-increment value, so the first RUN cycle stamps 0.
  - Writes to x0 are never recorded.
  - A write in the same cycle as the halt edge (RUN, halt=1) is captured.
  - No captures occur in IDLE, DRAIN or DONE.
  - rf_waddr >= NUM_REGS is not recorded and is not counted as a drop.
- FIFO:
  - Stores DEPTH entries in first-write-first-read order.
  - pop = out_valid & out_ready.
  - out_valid = !empty, driven from a registered entry (no combinational path from rf_* to out_*).
  - out_data is stable while out_valid=1 and out_ready=0.
  - Push into a full FIFO succeeds if a pop occurs in the same cycle.
  - Push into a full FIFO with no pop drops the record, and drop_count increments, saturating at all-ones.
  - Push plus pop on an empty FIFO: the new record becomes visible on the next cycle (no bypass).
  - Pointers wrap modulo DEPTH; full/empty use an extra pointer bit.
- Outputs: busy is combinational from state. done=1 only in DONE. cycle_count and drop_count stay readable after DONE.
- halt deasserting in DRAIN or DONE has no effect.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, RUN, DRAIN, DONE);
  - the trace-record field widths and offsets, with a helper for AW = clog2(NUM_REGS);
  - the record width constant.
- One sub-module: trace_fifo, parametrised in width and DEPTH, exposing push/pop/full/empty/rdata. The FSM, counters and capture gating live in cpu_trace_monitor.

Test Plan:
- Basic capture: reset, start, then writes x5=0x0000_00AA in RUN cycle 2 and x0=0x1234 in cycle 3, out_ready=1 -> exactly one record {2, 5, 0x0000_00AA}; no record for x0.
- Halt drain: 3 writes, halt on cycle 6 with a write to x7=0xDEAD_BEEF, out_ready=0 until cycle 10 -> busy=1 throughout. After out_ready rises: 4 records in order, the last {6, 7, 0xDEAD_BEEF}. done=1 one cycle after the final pop; cycle_count=7.
- Overflow: DEPTH=16, out_ready=0, 20 consecutive writes to x1 -> 16 records retained (stamps 0..15); drop_count=4.
- Full with simultaneous pop: fill 16, then out_ready=1 together with a write -> no drop, and the record is appended after the 16 existing ones.
- Backpressure stability: out_valid=1 with out_ready toggling 0/1 each cycle -> out_data never changes while out_ready=0.
- Reset mid-run: 5 records buffered in RUN, assert reset one cycle -> out_valid=0, cycle_count=0, drop_count=0, state IDLE. halt without start leaves done=0.

Source files
------------

// File: rtl/cpu_trace_monitor_pkg.sv
// Shared types and trace-record layout for the CPU trace monitor.
// A record is {cycle, addr, data}, with the cycle stamp in the MSBs.
package cpu_trace_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Address width for a register count (never less than 1 bit).
  function automatic int addr_w(input int num_regs);
    int w;
    w = 1;
    while ((1 << w) < num_regs) w++;
    return w;
  endfunction

  function automatic int rec_w(input int cyc_w, input int aw, input int xlen);
    return cyc_w + aw + xlen;
  endfunction

  localparam int DATA_LSB = 0;

  function automatic int addr_lsb(input int xlen);
    return xlen;
  endfunction

  function automatic int cyc_lsb(input int aw, input int xlen);
    return xlen + aw;
  endfunction

endpackage

// File: rtl/cpu_trace_monitor_trace_fifo.sv
// Synchronous FIFO with extra-bit pointers; a push into a full FIFO lands
// only when a pop frees a slot on the same edge.
module trace_fifo #(
  parameter int W     = 69,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[PW-1:0]] <= wdata;
  end

  // Head comes straight out of storage, so new pushes show up a cycle later.
  assign rdata = mem[rptr[PW-1:0]];

endmodule

// File: rtl/cpu_trace_monitor.sv
// Run monitor: stamps architectural register writes with the run cycle,
// queues them for a valid/ready consumer, and flags completion after halt.
module cpu_trace_monitor
  import cpu_trace_monitor_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int CYC_W    = 32,
  parameter int DEPTH    = 16,
  parameter int DROP_W   = 16,
  parameter int AW       = addr_w(NUM_REGS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    halt,
  input  logic                    rf_we,
  input  logic [AW-1:0]           rf_waddr,
  input  logic [XLEN-1:0]         rf_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CYC_W+AW+XLEN-1:0] out_data,
  output logic [CYC_W-1:0]        cycle_count,
  output logic [DROP_W-1:0]       drop_count,
  output logic                    busy,
  output logic                    done
);
  localparam int RW = rec_w(CYC_W, AW, XLEN);
  localparam logic [AW:0] NREGS = NUM_REGS[AW:0];

  state_t            state, state_nxt;
  logic [CYC_W-1:0]  cyc;
  logic [DROP_W-1:0] drops;
  logic              push, pop, full, empty, addr_ok;
  logic [RW-1:0]     rec, rdata;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (halt)  state_nxt = S_DRAIN;
      S_DRAIN: if (empty) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

  // x0 and out-of-range addresses never produce a record (and never count as drops).
  assign addr_ok = (rf_waddr != '0) && ({1'b0, rf_waddr} < NREGS);
  assign push    = (state == S_RUN) && rf_we && addr_ok;
  assign pop     = out_valid & out_ready;

  always_comb begin
    rec = '0;
    rec[DATA_LSB +: XLEN]         = rf_wdata;
    rec[addr_lsb(XLEN) +: AW]     = rf_waddr;
    rec[cyc_lsb(AW, XLEN) +: CYC_W] = cyc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc   <= '0;
      drops <= '0;
    end else begin
      if (state == S_RUN && cyc != '1) cyc <= cyc + 1'b1;
      if (push && full && !pop && drops != '1) drops <= drops + 1'b1;
    end
  end

  trace_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (rec),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign out_valid   = ~empty;
  assign out_data    = rdata;
  assign cycle_count = cyc;
  assign drop_count  = drops;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed and randomized bench for cpu_trace_monitor against a queue-based
// model of the trace stream, run counter and drop counter.
module tb_cpu_trace_monitor;
  localparam int XLEN = 32, NUM_REGS = 32, AW = 5, CYC_W = 32, DEPTH = 16, DROP_W = 16;
  localparam int RW = CYC_W + AW + XLEN;

  logic              clock = 1'b0;
  logic              reset, start, halt, rf_we, out_ready;
  logic [AW-1:0]     rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic              out_valid, busy, done;
  logic [RW-1:0]     out_data;
  logic [CYC_W-1:0]  cycle_count;
  logic [DROP_W-1:0] drop_count;

  cpu_trace_monitor #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .CYC_W(CYC_W),
                      .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clock(clock), .reset(reset), .start(start), .halt(halt),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cycle_count(cycle_count), .drop_count(drop_count),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;

  // Model: 0 idle, 1 run, 2 drain, 3 done
  logic [RW-1:0] q[$];
  longint        m_cyc;
  int            m_drops, m_st;
  logic          hold;
  logic [RW-1:0] hold_data, dut_last;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cyc = 0; m_drops = 0; m_st = 0; hold = 1'b0;
  endtask

  // Check outputs against the model, advance the model by one edge, clock once.
  task automatic step();
    int   sz;
    logic pp, cap;
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) chk("out_data", out_data, q[0]);
    if (hold) chk("stable", out_data, hold_data);
    chk("busy", busy, m_st == 1 || m_st == 2);
    chk("done", done, m_st == 3);
    chk("cycle_count", cycle_count, m_cyc[CYC_W-1:0]);
    chk("drop_count", drop_count, m_drops);
    if (out_valid && out_ready) dut_last = out_data;
    if (reset) begin
      model_reset();
    end else begin
      sz  = q.size();
      pp  = (sz != 0) && out_ready;
      cap = (m_st == 1) && rf_we && (rf_waddr != 0) && (int'(rf_waddr) < NUM_REGS);
      hold = (sz != 0) && !out_ready;
      if (hold) hold_data = q[0];
      if (pp) void'(q.pop_front());
      if (cap) begin
        if (sz < DEPTH || pp) q.push_back({m_cyc[CYC_W-1:0], rf_waddr, rf_wdata});
        else if (m_drops < (1 << DROP_W) - 1) m_drops++;
      end
      if (m_st == 1 && m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if (m_st == 0 && start)      m_st = 1;
      else if (m_st == 1 && halt)  m_st = 2;
      else if (m_st == 2 && sz == 0) m_st = 3;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
  endtask

  task automatic idle();
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic drain_to_done(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && m_st != 3; i++) step();
    step();
    chk(tag, done, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; out_ready = 1'b0; idle();
    model_reset();
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);

    // Basic capture
    out_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    wr(5, 32'h0000_00AA); step();
    chk("basic_rec", out_data, {32'd2, 5'd5, 32'h0000_00AA});
    wr(0, 32'h1234); step(); idle();
    chk("basic_x0", out_valid, 1'b0);
    step(); step();
    halt = 1'b1; step(); halt = 1'b0;
    drain_to_done("basic_done");

    // Halt drain with backpressure
    do_reset();
    out_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step();
    for (int c = 1; c <= 3; c++) begin wr(AW'(c + 1), $urandom); step(); end
    idle(); step(); step();
    wr(7, 32'hDEAD_BEEF); halt = 1'b1; step(); idle(); halt = 1'b0;
    chk("halt_cycles", cycle_count, 7);
    for (int c = 7; c <= 9; c++) begin chk("halt_busy", busy, 1'b1); step(); end
    drain_to_done("halt_done");
    chk("halt_last", dut_last, {32'd6, 5'd7, 32'hDEAD_BEEF});
    chk("halt_cycles_frozen", cycle_count, 7);

    // Overflow, then full with simultaneous pop, then toggling backpressure
    do_reset();
    out_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin wr(1, $urandom); step(); end
    chk("ovf_drops", drop_count, 4);
    chk("ovf_head_stamp", out_data[RW-1 -: CYC_W], 0);
    out_ready = 1'b1; wr(2, $urandom); step(); idle();
    chk("fullpop_drops", drop_count, 4);
    for (int i = 0; i < 40; i++) begin out_ready = i[0]; step(); end
    halt = 1'b1; step(); halt = 1'b0;
    drain_to_done("ovf_done");

    // Randomized run
    do_reset();
    start = 1'b1; step();
    for (int i = 0; i < 300; i++) begin
      start     = ($urandom % 8) == 0;
      rf_we     = $urandom % 2;
      rf_waddr  = AW'($urandom % 32);
      rf_wdata  = $urandom;
      out_ready = ($urandom % 4) != 0;
      halt      = (i >= 250) ? ($urandom % 2) : 1'b0;
      step();
    end
    idle(); halt = 1'b0; start = 1'b0;
    drain_to_done("rand_done");

    // Reset mid-run, then halt without start
    do_reset();
    out_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin wr(AW'(3 + i), $urandom); step(); end
    idle();
    chk("mid_buffered", out_valid, 1'b1);
    do_reset();
    chk("mid_valid", out_valid, 1'b0);
    chk("mid_cycles", cycle_count, 0);
    chk("mid_drops", drop_count, 0);
    chk("mid_busy", busy, 1'b0);
    halt = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("nostart_done", done, 1'b0);
    halt = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
